regfile_scheduler: RTL and testbench

REGFILE_SCHEDULER -- requirements
Module: regfile_scheduler

---
 rtl/regfile_scheduler.sv | 159 +++++++++++++++
 tb/tb_regfile_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_scheduler.sv
// Register-file load/read scheduler: streams load_len words into the register file,
// then sweeps them back as 4-lane read beats for `passes` passes.
module regfile_scheduler #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [5:0]        load_len,
  input  logic [3:0]        passes,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              rf_wr_en,
  output logic [4:0]        rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [4:0]        rf_rd_addr1,
  output logic [4:0]        rf_rd_addr2,
  output logic [4:0]        rf_rd_addr3,
  output logic [4:0]        rf_rd_addr4,
  output logic              rd_valid,
  output logic [3:0]        rd_lane,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, READ, DONE} state_t;

  localparam logic [6:0] MAX_LEN = 7'(DEPTH);

  state_t            state_q, state_d;
  logic [5:0]        len_q, len_d;
  logic [3:0]        passes_q, passes_d;
  logic [5:0]        wcnt_q, wcnt_d;
  logic [5:0]        base_q, base_d;
  logic [3:0]        pcnt_q, pcnt_d;
  logic              wr_en_q, wr_en_d;
  logic [4:0]        wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              err_q, err_d;

  logic              legal;
  logic [3:0]        lane_ok;
  logic [3:0][4:0]   lane_addr;
  logic [6:0]        lane_idx;

  assign legal = (load_len != 6'd0) && ({1'b0, load_len} <= MAX_LEN) && (passes != 4'd0);

  always_comb begin
    lane_ok   = '0;
    lane_addr = '0;
    lane_idx  = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      lane_idx     = {1'b0, base_q} + 7'(k);
      lane_ok[k]   = lane_idx < {1'b0, len_q};
      lane_addr[k] = lane_ok[k] ? lane_idx[4:0] : 5'd0;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    passes_d  = passes_q;
    wcnt_d    = wcnt_q;
    base_d    = base_q;
    pcnt_d    = pcnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (legal) begin
            len_d    = load_len;
            passes_d = passes;
            wcnt_d   = '0;
            base_d   = '0;
            pcnt_d   = '0;
            state_d  = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (s_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = wcnt_q[4:0];
          wr_data_d = s_data;
          // Final word leaves wcnt at len-1 so it never passes the latched limit.
          if (wcnt_q == len_q - 6'd1) state_d = SETTLE;
          else                        wcnt_d  = wcnt_q + 6'd1;
        end
      end
      SETTLE: state_d = READ;
      READ: begin
        if (rd_ready) begin
          if ({1'b0, base_q} + 7'd4 >= {1'b0, len_q}) begin
            base_d = '0;
            pcnt_d = pcnt_q + 4'd1;
            if (pcnt_q + 4'd1 == passes_q) state_d = DONE;
          end else begin
            base_d = base_q + 6'd4;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      passes_q  <= '0;
      wcnt_q    <= '0;
      base_q    <= '0;
      pcnt_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      passes_q  <= passes_d;
      wcnt_q    <= wcnt_d;
      base_q    <= base_d;
      pcnt_q    <= pcnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  // Outputs are forced low while rst is high, independent of the pending edge.
  logic in_read;
  assign in_read     = !rst && (state_q == READ);
  assign s_ready     = !rst && (state_q == LOAD);
  assign rf_wr_en    = !rst && wr_en_q;
  assign rf_wr_addr  = rst ? '0 : wr_addr_q;
  assign rf_wr_data  = rst ? '0 : wr_data_q;
  assign rd_valid    = in_read;
  assign rd_lane     = in_read ? lane_ok : '0;
  assign rf_rd_addr1 = in_read ? lane_addr[0] : '0;
  assign rf_rd_addr2 = in_read ? lane_addr[1] : '0;
  assign rf_rd_addr3 = in_read ? lane_addr[2] : '0;
  assign rf_rd_addr4 = in_read ? lane_addr[3] : '0;
  assign busy        = !rst && (state_q != IDLE);
  assign done        = !rst && (state_q == DONE);
  assign err         = !rst && err_q;

endmodule

// File: tb/tb_regfile_scheduler.sv
// Directed bench for regfile_scheduler: expected writes and read beats are queued
// when stimulus is applied and checked as the DUT produces them.
module tb_regfile_scheduler;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, start, s_valid, s_ready, rf_wr_en, rd_valid, rd_ready;
  logic          busy, done, err;
  logic [5:0]    load_len;
  logic [3:0]    passes, rd_lane;
  logic [DW-1:0] s_data, rf_wr_data;
  logic [4:0]    rf_wr_addr, rf_rd_addr1, rf_rd_addr2, rf_rd_addr3, rf_rd_addr4;

  regfile_scheduler #(.DATA_W(DW), .DEPTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .load_len(load_len), .passes(passes),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_addr3(rf_rd_addr3), .rf_rd_addr4(rf_rd_addr4),
    .rd_valid(rd_valid), .rd_lane(rd_lane), .rd_ready(rd_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [4:0] a; logic [DW-1:0] d; int due;} wr_t;
  typedef struct {logic [19:0] a; logic [3:0] lane;} beat_t;

  wr_t   wq[$];
  beat_t bq[$];
  int    vectors = 0, miscompares = 0;
  int    cyc_n = 0, wi = 0, done_cnt = 0, err_cnt = 0;
  logic  acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    wr_t   w;
    beat_t b;
    acc = s_valid && s_ready;
    if (acc) wq.push_back('{a: 5'(wi), d: s_data, due: cyc_n + 1});
    if (rf_wr_en) begin
      if (wq.size() == 0) chk("wr_unexpected", {31'd0, rf_wr_en}, 32'd0);
      else begin
        w = wq.pop_front();
        chk("wr_addr", {27'd0, rf_wr_addr}, {27'd0, w.a});
        chk("wr_data", {24'd0, rf_wr_data}, {24'd0, w.d});
        chk("wr_latency", cyc_n, w.due);
      end
    end
    if (rd_valid) begin
      if (bq.size() == 0) chk("rd_unexpected", {31'd0, rd_valid}, 32'd0);
      else begin
        b = bq[0];
        chk(rd_ready ? "beat_addr" : "stall_addr",
            {12'd0, rf_rd_addr4, rf_rd_addr3, rf_rd_addr2, rf_rd_addr1}, {12'd0, b.a});
        chk(rd_ready ? "beat_lane" : "stall_lane", {28'd0, rd_lane}, {28'd0, b.lane});
        if (rd_ready) void'(bq.pop_front());
      end
    end
    if (done) done_cnt++;
    if (err)  err_cnt++;
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"},
        {19'd0, s_ready, rf_wr_en, rd_valid, busy, done, err, rd_lane, s_ready, rf_wr_en},
        32'd0);
    chk({tag, "_wr"}, {19'd0, rf_wr_addr, rf_wr_data}, 32'd0);
    chk({tag, "_rd"}, {12'd0, rf_rd_addr4, rf_rd_addr3, rf_rd_addr2, rf_rd_addr1}, 32'd0);
  endtask

  task automatic push_beats(input int len, input int np);
    beat_t b;
    int    idx;
    for (int p = 0; p < np; p++)
      for (int bb = 0; bb < (len + 3) / 4; bb++) begin
        b.a = '0; b.lane = '0;
        for (int k = 0; k < 4; k++) begin
          idx = bb * 4 + k;
          b.lane[k] = idx < len;
          b.a[k*5 +: 5] = (idx < len) ? 5'(idx) : 5'd0;
        end
        bq.push_back(b);
      end
  endtask

  task automatic run_job(input int len, input int np, input int dbase,
                         input bit stall, input bit bp, input int abort_at);
    int k, r;
    done_cnt = 0; err_cnt = 0; wi = 0;
    start = 1'b1; load_len = 6'(len); passes = 4'(np);
    cyc();
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("s_ready_in_load", {31'd0, s_ready}, 32'd1);
    push_beats(len, np);
    k = 0;
    while (wi < len && k < 400) begin
      start    = (k == 1);
      load_len = (k == 1) ? 6'd0 : 6'(len);
      s_valid  = stall ? (k % 3 == 0) : 1'b1;
      s_data   = DW'(dbase + wi);
      cyc();
      if (acc) wi++;
      k++;
    end
    start = 1'b0; s_valid = 1'b0;
    chk("load_complete", wi, len);
    chk("settle_state", {29'd0, rd_valid, busy, s_ready}, 32'b010);
    r = 0;
    while (done_cnt == 0 && r < 600) begin
      if (abort_at >= 0 && r == abort_at) break;
      rd_ready = bp ? !(r >= 3 && r < 6) : 1'b1;
      cyc();
      r++;
    end
    rd_ready = 1'b0;
    if (abort_at >= 0) begin
      chk("abort_in_read", {31'd0, rd_valid}, 32'd1);
      return;
    end
    chk("done_pulses", done_cnt, 1);
    chk("done_one_cycle", {30'd0, done, busy}, 32'd0);
    chk("beats_left", bq.size(), 0);
    chk("writes_left", wq.size(), 0);
    chk("no_err_in_job", err_cnt, 0);
  endtask

  task automatic illegal(input logic [5:0] len, input logic [3:0] np);
    start = 1'b1; load_len = len; passes = np;
    cyc();
    start = 1'b0;
    chk("illegal_err", {30'd0, err, busy}, 32'b10);
    cyc();
    chk("illegal_err_drop", {30'd0, err, busy}, 32'b00);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; load_len = '0; passes = '0;
    s_data = '0; s_valid = 1'b0; rd_ready = 1'b0;
    cyc(); cyc();
    chk_all_zero("reset");
    rst = 1'b0;
    cyc();
    chk_all_zero("idle");

    run_job(6, 2, 'h10, 1'b0, 1'b0, -1);
    run_job(7, 1, 'h40, 1'b1, 1'b0, -1);
    run_job(16, 1, 'h80, 1'b0, 1'b1, -1);

    illegal(6'd0, 4'd1);
    illegal(6'd33, 4'd1);
    illegal(6'd4, 4'd0);
    chk("illegal_no_writes", wq.size(), 0);

    run_job(32, 1, 'hA0, 1'b0, 1'b0, -1);
    run_job(13, 3, 'h20, 1'b1, 1'b1, -1);

    run_job(8, 2, 'h60, 1'b0, 1'b0, 3);
    rst = 1'b1;
    #1;
    chk_all_zero("abort_rst_pre");
    cyc();
    chk_all_zero("abort_rst_post");
    rst = 1'b0;
    bq.delete();
    chk("abort_writes_left", wq.size(), 0);
    cyc();
    chk_all_zero("abort_idle");
    run_job(4, 1, 'hC0, 1'b0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
